// File: rtl/oven_timer_pkg.sv
// Purpose : shared types and constants for the oven countdown timer.
// Latency : n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
//
// Contents: BCD digit type, FSM state enum, digit limits, and a
// binary-to-BCD helper for preset values 0..99.
package oven_timer_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } timer_state_t;

    localparam bcd_t       SEC_TENS_MAX = 4'd5;
    localparam bcd_t       DIGIT_MAX    = 4'd9;
    localparam logic [5:0] SEC_MAX      = 6'd59;

    // Two-digit binary to BCD by repeated subtraction of ten. Input must
    // be <= 99. Nine unrolled compare/subtract steps avoid a divider.
    function automatic logic [7:0] bin_to_bcd2(input logic [6:0] value);
        logic [3:0] tens;
        logic [6:0] rest;
        tens = 4'd0;
        rest = value;
        for (int i = 0; i < 9; i++) begin
            if (rest >= 7'd10) begin
                rest = rest - 7'd10;
                tens = tens + 4'd1;
            end
        end
        return {tens, 4'(rest)};
    endfunction

endpackage

// File: rtl/oven_tick_prescaler.sv
// Purpose : divides the clock down to a one-cycle tick once per second.
// Latency : tick is combinational from the count; count updates each edge.
// Backpressure: enable low freezes the count; clear overrides enable.
//
// Ports:
//   clock  - rising-edge clock
//   reset  - asynchronous active-high reset, count -> 0
//   clear  - synchronous clear of the count to 0
//   enable - advance the count this cycle
//   tick   - high in the enabled cycle where count == TICKS_PER_SEC-1
module oven_tick_prescaler #(
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int              CW   = $clog2(TICKS_PER_SEC);
    localparam logic [CW-1:0]   LAST = CW'(TICKS_PER_SEC - 1);

    logic [CW-1:0] count;

    assign tick = enable && (count == LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/oven_countdown_timer.sv
// Purpose : programmable MM:SS countdown timer with start/pause/cancel and done.
// Latency : controls act on the next edge; digits/running/done are registered.
// Backpressure: none; level inputs sampled every cycle, cancel>pause>start>set_valid.
//
// Ports:
//   clock, reset         - clock, asynchronous active-high reset
//   set_valid/min/sec    - preset load (binary, clamped to MAX_MIN:59)
//   start, pause, cancel - run control
//   sec_units..min_tens  - BCD display digits
//   running              - high while counting down
//   done                 - one-cycle pulse when the count reaches 00:00
//   alarm                - buzzer enable; built only with OVEN_TIMER_ALARM_EN,
//                          otherwise tied low
module oven_countdown_timer
    import oven_timer_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int MAX_MIN       = 99,
    parameter int ALARM_SEC     = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       set_valid,
    input  logic [6:0] set_min,
    input  logic [5:0] set_sec,
    input  logic       start,
    input  logic       pause,
    input  logic       cancel,
    output logic [3:0] sec_units,
    output logic [3:0] sec_tens,
    output logic [3:0] min_units,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       done,
    output logic       alarm
);

    // Elaboration-time parameter sanity checks.
    if (TICKS_PER_SEC < 2) begin : g_bad_tps
        $error("TICKS_PER_SEC must be >= 2");
    end
    if (MAX_MIN < 1 || MAX_MIN > 99) begin : g_bad_max_min
        $error("MAX_MIN must be in 1..99");
    end
    if (ALARM_SEC < 1) begin : g_bad_alarm_sec
        $error("ALARM_SEC must be >= 1");
    end

    localparam logic [6:0] MAX_MIN_L = 7'(MAX_MIN);

    timer_state_t state;

    logic tick;
    logic presc_clear;
    logic presc_enable;
    logic alarm_active;

    // ---------------- preset conversion ----------------
    logic [6:0] min_clamped;
    logic [5:0] sec_clamped;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;

    always_comb begin
        min_clamped = (set_min > MAX_MIN_L) ? MAX_MIN_L : set_min;
        sec_clamped = (set_sec > SEC_MAX) ? SEC_MAX : set_sec;
        min_bcd     = bin_to_bcd2(min_clamped);
        sec_bcd     = bin_to_bcd2({1'b0, sec_clamped});
    end

    // ---------------- BCD decrement with borrow chain ----------------
    bcd_t dec_su, dec_st, dec_mu, dec_mt;
    logic borrow_st, borrow_mu, borrow_mt;
    logic time_zero, dec_zero;

    always_comb begin
        borrow_st = (sec_units == 4'd0);
        borrow_mu = borrow_st && (sec_tens == 4'd0);
        borrow_mt = borrow_mu && (min_units == 4'd0);

        dec_su = borrow_st ? DIGIT_MAX : sec_units - 4'd1;

        dec_st = sec_tens;
        if (borrow_st) begin
            dec_st = (sec_tens == 4'd0) ? SEC_TENS_MAX : sec_tens - 4'd1;
        end

        dec_mu = min_units;
        if (borrow_mu) begin
            dec_mu = (min_units == 4'd0) ? DIGIT_MAX : min_units - 4'd1;
        end

        // Only ever decremented from a non-zero time, so min_tens never wraps.
        dec_mt = borrow_mt ? min_tens - 4'd1 : min_tens;

        time_zero = ({min_tens, min_units, sec_tens, sec_units} == 16'h0000);
        dec_zero  = ({dec_mt, dec_mu, dec_st, dec_su} == 16'h0000);
    end

    // ---------------- prescaler ----------------
    always_comb begin
        presc_clear  = cancel || (state == ST_IDLE && start && !time_zero);
        // Pause freezes the partial second; in DONE it only runs to time the alarm.
        presc_enable = (state == ST_RUN && !pause) || alarm_active;
    end

    oven_tick_prescaler #(
        .TICKS_PER_SEC (TICKS_PER_SEC)
    ) u_prescaler (
        .clock  (clock),
        .reset  (reset),
        .clear  (presc_clear),
        .enable (presc_enable),
        .tick   (tick)
    );

    // ---------------- control FSM and digits ----------------
    // pause only has meaning in RUN/PAUSE; an input that is ignored in a
    // state does not block a lower-priority one (e.g. start at 00:00 in IDLE
    // still lets set_valid load).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            sec_units <= 4'd0;
            sec_tens  <= 4'd0;
            min_units <= 4'd0;
            min_tens  <= 4'd0;
            running   <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (cancel) begin
                state     <= ST_IDLE;
                sec_units <= 4'd0;
                sec_tens  <= 4'd0;
                min_units <= 4'd0;
                min_tens  <= 4'd0;
                running   <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start && !time_zero) begin
                            state   <= ST_RUN;
                            running <= 1'b1;
                        end else if (set_valid) begin
                            {min_tens, min_units} <= min_bcd;
                            {sec_tens, sec_units} <= sec_bcd;
                        end
                    end
                    ST_RUN: begin
                        if (pause) begin
                            state   <= ST_PAUSE;
                            running <= 1'b0;
                        end else if (tick) begin
                            sec_units <= dec_su;
                            sec_tens  <= dec_st;
                            min_units <= dec_mu;
                            min_tens  <= dec_mt;
                            if (dec_zero) begin
                                state   <= ST_DONE;
                                running <= 1'b0;
                                done    <= 1'b1;
                            end
                        end
                    end
                    ST_PAUSE: begin
                        if (start && !pause) begin
                            state   <= ST_RUN;
                            running <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        if (set_valid) begin
                            state <= ST_IDLE;
                            {min_tens, min_units} <= min_bcd;
                            {sec_tens, sec_units} <= sec_bcd;
                        end
                    end
                    default: begin
                        state   <= ST_IDLE;
                        running <= 1'b0;
                    end
                endcase
            end
        end
    end

    // ---------------- optional alarm ----------------
`ifdef OVEN_TIMER_ALARM_EN
    localparam int AW = $clog2(ALARM_SEC + 1);

    logic [AW-1:0] alarm_secs;
    logic          alarm_q;

    assign alarm        = alarm_q;
    assign alarm_active = alarm_q && (state == ST_DONE);

    // Prescaler wraps to 0 on the final tick, so whole seconds of alarm are
    // counted from the DONE entry edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            alarm_q    <= 1'b0;
            alarm_secs <= '0;
        end else if (cancel) begin
            alarm_q    <= 1'b0;
            alarm_secs <= '0;
        end else if (state == ST_RUN && !pause && tick && dec_zero) begin
            alarm_q    <= 1'b1;
            alarm_secs <= '0;
        end else if (state == ST_DONE && set_valid) begin
            alarm_q    <= 1'b0;
            alarm_secs <= '0;
        end else if (alarm_active && tick) begin
            if (alarm_secs == AW'(ALARM_SEC - 1)) begin
                alarm_q <= 1'b0;
            end
            alarm_secs <= alarm_secs + 1'b1;
        end
    end
`else
    assign alarm        = 1'b0;
    assign alarm_active = 1'b0;
`endif

endmodule

// File: tb/tb_oven_countdown_timer.sv
// Purpose : self-checking bench for oven_countdown_timer (TICKS_PER_SEC = 4).
// Latency : reference model stepped once per clock edge, outputs compared #1 later.
// Backpressure: n/a.
module tb_oven_countdown_timer;

    localparam int TPS     = 4;
    localparam int MAXM    = 99;
    localparam int ALARM_S = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic       set_valid;
    logic [6:0] set_min;
    logic [5:0] set_sec;
    logic       start;
    logic       pause;
    logic       cancel;
    logic [3:0] sec_units, sec_tens, min_units, min_tens;
    logic       running, done, alarm;

    always #5 clock = ~clock;

    oven_countdown_timer #(
        .TICKS_PER_SEC (TPS),
        .MAX_MIN       (MAXM),
        .ALARM_SEC     (ALARM_S)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .set_valid (set_valid),
        .set_min   (set_min),
        .set_sec   (set_sec),
        .start     (start),
        .pause     (pause),
        .cancel    (cancel),
        .sec_units (sec_units),
        .sec_tens  (sec_tens),
        .min_units (min_units),
        .min_tens  (min_tens),
        .running   (running),
        .done      (done),
        .alarm     (alarm)
    );

    // ---------------- reference model ----------------
    // Remaining time is a plain count of seconds; the display is derived
    // from it with division, and a second elapses every TPS running cycles.
    typedef enum int {M_IDLE, M_RUN, M_HOLD, M_FIN} mode_e;

    mode_e m_mode;
    int    m_secs;
    int    m_phase;
    int    m_alarm_left;
    bit    m_done;

    int tests_run   = 0;
    int tests_fail  = 0;
    int done_seen   = 0;
    int alarm_seen  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mode       = M_IDLE;
        m_secs       = 0;
        m_phase      = 0;
        m_alarm_left = 0;
        m_done       = 1'b0;
    endtask

    function automatic int preset_secs(input int mn, input int sc);
        int m2, s2;
        m2 = (mn > MAXM) ? MAXM : mn;
        s2 = (sc > 59) ? 59 : sc;
        return m2 * 60 + s2;
    endfunction

    task automatic model_step();
        m_done = 1'b0;
        if (cancel) begin
            m_mode       = M_IDLE;
            m_secs       = 0;
            m_phase      = 0;
            m_alarm_left = 0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (start && m_secs > 0) begin
                        m_mode  = M_RUN;
                        m_phase = 0;
                    end else if (set_valid) begin
                        m_secs = preset_secs(int'(set_min), int'(set_sec));
                    end
                end
                M_RUN: begin
                    if (pause) begin
                        m_mode = M_HOLD;
                    end else if (m_phase == TPS - 1) begin
                        m_phase = 0;
                        m_secs  = m_secs - 1;
                        if (m_secs == 0) begin
                            m_mode       = M_FIN;
                            m_done       = 1'b1;
                            m_alarm_left = ALARM_S * TPS;
                        end
                    end else begin
                        m_phase = m_phase + 1;
                    end
                end
                M_HOLD: begin
                    if (!pause && start) m_mode = M_RUN;
                end
                M_FIN: begin
                    if (set_valid) begin
                        m_secs       = preset_secs(int'(set_min), int'(set_sec));
                        m_mode       = M_IDLE;
                        m_alarm_left = 0;
                    end else if (m_alarm_left > 0) begin
                        m_alarm_left = m_alarm_left - 1;
                    end
                end
                default: m_mode = M_IDLE;
            endcase
        end
    endtask

    task automatic compare_all();
        int mm, ss;
        logic [31:0] exp_dig;
        logic        exp_alarm;
        mm = m_secs / 60;
        ss = m_secs % 60;
        exp_dig = 32'((mm / 10) * 4096 + (mm % 10) * 256 + (ss / 10) * 16 + (ss % 10));
`ifdef OVEN_TIMER_ALARM_EN
        exp_alarm = (m_alarm_left > 0);
`else
        exp_alarm = 1'b0;
`endif
        check_eq("digits",  {16'h0, min_tens, min_units, sec_tens, sec_units}, exp_dig);
        check_eq("running", {31'h0, running}, {31'h0, m_mode == M_RUN});
        check_eq("done",    {31'h0, done},    {31'h0, m_done});
        check_eq("alarm",   {31'h0, alarm},   {31'h0, exp_alarm});
        if (done)  done_seen++;
        if (alarm) alarm_seen++;
    endtask

    // Drive inputs (just after an edge), clock one edge, model it, compare.
    task automatic step(input logic c, input logic p, input logic s, input logic v,
                        input logic [6:0] mn, input logic [5:0] sc);
        cancel    = c;
        pause     = p;
        start     = s;
        set_valid = v;
        set_min   = mn;
        set_sec   = sc;
        @(posedge clock);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 6'd0);
    endtask

    task automatic load(input logic [6:0] mn, input logic [5:0] sc);
        step(1'b0, 1'b0, 1'b0, 1'b1, mn, sc);
    endtask

    task automatic go();
        step(1'b0, 1'b0, 1'b1, 1'b0, 7'd0, 6'd0);
    endtask

    task automatic do_cancel();
        step(1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 6'd0);
    endtask

    logic pause_lvl;

    initial begin
        reset = 1'b1;
        cancel = 1'b0; pause = 1'b0; start = 1'b0; set_valid = 1'b0;
        set_min = 7'd0; set_sec = 6'd0;
        model_reset();
        #3;
        compare_all();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Load 1:05 and run to completion: 65 ticks of 4 cycles.
        load(7'd1, 6'd5);
        go();
        done_seen = 0;
        idle(262);
        check_eq("done_count", 32'(done_seen), 32'd1);

        // Clamp to 99:59, then 10:00 -> 09:59 after one tick.
        do_cancel();
        load(7'd120, 6'd75);
        load(7'd10, 6'd0);
        go();
        idle(5);

        // Pause two cycles into a second, hold 20 cycles, resume.
        do_cancel();
        load(7'd0, 6'd10);
        go();
        idle(2);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 6'd0);
        go();
        idle(6);

        // start at 00:00 is ignored; DONE ignores start, accepts a new preset.
        do_cancel();
        go();
        idle(3);
        load(7'd0, 6'd1);
        go();
        idle(4);
        go();
        load(7'd0, 6'd3);
        idle(2);

        // cancel coinciding with the final tick.
        do_cancel();
        load(7'd0, 6'd1);
        go();
        idle(3);
        done_seen = 0;
        do_cancel();
        idle(4);
        check_eq("cancel_no_done", 32'(done_seen), 32'd0);

`ifdef OVEN_TIMER_ALARM_EN
        // Alarm lasts ALARM_S seconds, then a second run is cancelled early.
        load(7'd0, 6'd1);
        go();
        alarm_seen = 0;
        idle(16);
        check_eq("alarm_len", 32'(alarm_seen), 32'(ALARM_S * TPS));
        load(7'd0, 6'd1);
        go();
        idle(4);
        idle(2);
        do_cancel();
        idle(3);
`endif

        // Asynchronous reset between edges, mid-run.
        load(7'd0, 6'd30);
        go();
        idle(5);
        #3 reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        #1 reset = 1'b0;
        idle(2);

        // Randomised run against the model.
        pause_lvl = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            logic       c, s, v;
            logic [6:0] mn;
            logic [5:0] sc;
            if ($urandom_range(0, 39) == 0) pause_lvl = ~pause_lvl;
            c  = ($urandom_range(0, 299) == 0);
            s  = ($urandom_range(0, 7) == 0);
            v  = ($urandom_range(0, 24) == 0);
            mn = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 1));
            sc = 6'($urandom_range(0, 63));
            step(c, pause_lvl, s, v, mn, sc);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
        $finish;
    end

endmodule
